// File: rtl/branch_target_predictor.sv
// branch_target_predictor
//
// Fetch-stage branch predictor: a direct-mapped branch target buffer with a
// saturating direction counter per entry. The lookup is combinational and
// drives the fetch predict-select (0 = STD next PC, 1 = PDT predicted target).
// The resolving stage trains the table with actual outcomes, one branch per
// cycle. Two saturating performance counters track resolved branches and
// mispredicts.
//
// Ports:
//   CLK              clock, all state updates on the rising edge
//   RST              asynchronous active-high reset
//   lkup_pc          fetch PC to predict
//   pred_sel         0 = STD, 1 = PDT
//   pred_target      predicted target, 0 whenever pred_sel = 0
//   upd_en           a resolved branch is presented this cycle
//   upd_pc           PC of the resolved branch
//   upd_taken        actual direction
//   upd_target       actual taken target
//   upd_mispredict   resolving stage flushed for this branch (qualified by upd_en)
//   stat_branches    saturating resolved-branch count
//   stat_mispredicts saturating mispredict count
//
// ENTRIES must be a power of two and at least 2; CTR_W must be at least 1.

module branch_target_predictor #(
   parameter int unsigned PC_W    = 32,
   parameter int unsigned ENTRIES = 16,
   parameter int unsigned CTR_W   = 2,
   parameter int unsigned STAT_W  = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [PC_W-1:0]   lkup_pc,
   output logic              pred_sel,
   output logic [PC_W-1:0]   pred_target,
   input  logic              upd_en,
   input  logic [PC_W-1:0]   upd_pc,
   input  logic              upd_taken,
   input  logic [PC_W-1:0]   upd_target,
   input  logic              upd_mispredict,
   output logic [STAT_W-1:0] stat_branches,
   output logic [STAT_W-1:0] stat_mispredicts
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned TAG_W = PC_W - IDX_W - 2;

   // Counter encodings: all ones, weakly-not-taken (0 then ones) and
   // weakly-taken (1 then zeros). For CTR_W = 1 these collapse to 1 / 0 / 1.
   localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
   localparam logic [CTR_W-1:0] CTR_WNT = CTR_MAX >> 1;
   localparam logic [CTR_W-1:0] CTR_WT  = ~CTR_WNT;
   localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

   // ------------------------------------------------------------------
   // Table storage (flip-flops only)
   // ------------------------------------------------------------------
   logic             valid_q  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [PC_W-1:0]  target_q [ENTRIES];
   logic [CTR_W-1:0] ctr_q    [ENTRIES];

   logic             valid_d  [ENTRIES];
   logic [TAG_W-1:0] tag_d    [ENTRIES];
   logic [PC_W-1:0]  target_d [ENTRIES];
   logic [CTR_W-1:0] ctr_d    [ENTRIES];

   logic [STAT_W-1:0] stat_branches_q, stat_branches_d;
   logic [STAT_W-1:0] stat_mispredicts_q, stat_mispredicts_d;

   // ------------------------------------------------------------------
   // Address decomposition; pc[1:0] carries no information
   // ------------------------------------------------------------------
   logic [IDX_W-1:0] lkup_idx;
   logic [TAG_W-1:0] lkup_tag;
   logic [IDX_W-1:0] upd_idx;
   logic [TAG_W-1:0] upd_tag;
   logic             unused_pc_lsbs;

   assign lkup_idx       = lkup_pc[IDX_W+1:2];
   assign lkup_tag       = lkup_pc[PC_W-1:IDX_W+2];
   assign upd_idx        = upd_pc[IDX_W+1:2];
   assign upd_tag        = upd_pc[PC_W-1:IDX_W+2];
   assign unused_pc_lsbs = ^{lkup_pc[1:0], upd_pc[1:0]};

   // ------------------------------------------------------------------
   // Lookup: reads registered state only, so a same-cycle update to the
   // same index is not bypassed and becomes visible one cycle later.
   // ------------------------------------------------------------------
   logic lkup_hit;

   always_comb begin
      lkup_hit    = valid_q[lkup_idx] && (tag_q[lkup_idx] == lkup_tag);
      pred_sel    = lkup_hit && ctr_q[lkup_idx][CTR_W-1];
      pred_target = pred_sel ? target_q[lkup_idx] : '0;
   end

   // ------------------------------------------------------------------
   // Training next-state
   // ------------------------------------------------------------------
   logic             upd_hit;
   logic [CTR_W-1:0] upd_ctr;

   assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
   assign upd_ctr = ctr_q[upd_idx];

   always_comb begin
      for (int i = 0; i < ENTRIES; i++) begin
         valid_d[i]  = valid_q[i];
         tag_d[i]    = tag_q[i];
         target_d[i] = target_q[i];
         ctr_d[i]    = ctr_q[i];
      end

      if (upd_en) begin
         if (upd_hit) begin
            if (upd_taken) begin
               if (upd_ctr != CTR_MAX) begin
                  ctr_d[upd_idx] = upd_ctr + 1'b1;
               end
               target_d[upd_idx] = upd_target;
            end else if (upd_ctr != '0) begin
               ctr_d[upd_idx] = upd_ctr - 1'b1;
            end
         end else if (upd_taken) begin
            // Allocate, evicting whatever aliased into this slot.
            valid_d[upd_idx]  = 1'b1;
            tag_d[upd_idx]    = upd_tag;
            target_d[upd_idx] = upd_target;
            ctr_d[upd_idx]    = CTR_WT;
         end
      end
   end

   // ------------------------------------------------------------------
   // Statistics next-state, saturating
   // ------------------------------------------------------------------
   always_comb begin
      stat_branches_d    = stat_branches_q;
      stat_mispredicts_d = stat_mispredicts_q;
      if (upd_en) begin
         if (stat_branches_q != STAT_MAX) begin
            stat_branches_d = stat_branches_q + 1'b1;
         end
         if (upd_mispredict && (stat_mispredicts_q != STAT_MAX)) begin
            stat_mispredicts_d = stat_mispredicts_q + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CTR_WNT;
         end
         stat_branches_q    <= '0;
         stat_mispredicts_q <= '0;
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= valid_d[i];
            tag_q[i]    <= tag_d[i];
            target_q[i] <= target_d[i];
            ctr_q[i]    <= ctr_d[i];
         end
         stat_branches_q    <= stat_branches_d;
         stat_mispredicts_q <= stat_mispredicts_d;
      end
   end

   assign stat_branches    = stat_branches_q;
   assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Parametrised branch predictor for the fetch stage. It combines a direct-mapped branch target buffer with saturating direction counters.
- It drives the fetch predict-select (STD/PDT) and the predicted target. It is trained by the resolving stage with actual branch outcomes.
- It keeps saturating performance counters for resolved branches and mispredicts.
- It supersedes the fixed STD/PDT select: the select is now derived from per-entry history instead of a static policy.

Parameters:
- PC_W, 32, program-counter width in bits.
- ENTRIES, 16, BTB entries; power of 2, minimum 2. IDX_W = log2(ENTRIES).
- CTR_W, 2, direction-counter width; minimum 1.
- STAT_W, 32, performance-counter width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- lkup_pc  in  PC_W  fetch PC to predict.
- pred_sel  out  1  0 = STD (use next PC), 1 = PDT (use pred_target).
- pred_target  out  PC_W  predicted target; 0 when pred_sel = 0.
- upd_en  in  1  a resolved branch is presented this cycle.
- upd_pc  in  PC_W  PC of the resolved branch.
- upd_taken  in  1  actual direction.
- upd_target  in  PC_W  actual taken target.
- upd_mispredict  in  1  the resolving stage flushed for this branch; sampled only with upd_en.
- stat_branches  out  STAT_W  resolved-branch count.
- stat_mispredicts  out  STAT_W  mispredict count.

Behaviour:
- Index and tag:
  - index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]; pc[1:0] ignored.
- Entry state: valid bit, tag, target (PC_W), counter (CTR_W).
- Reset (asynchronous, RST = 1):
  - all valid bits = 0; all counters = weakly-not-taken, i.e. 0 followed by all ones (01 for CTR_W = 2).
  - stat_branches = stat_mispredicts = 0; hence pred_sel = 0 and pred_target = 0 while RST is high.
  - An update in flight when RST asserts is discarded.
- Lookup (combinational, zero latency):
  - hit = valid[index] and tag match.
  - pred_sel = hit and counter MSB = 1; pred_target = stored target when pred_sel = 1, else 0.
- Update (registered, applied at the edge after upd_en is sampled):
  - Hit, taken: counter increments, saturating at all ones; target <= upd_target.
  - Hit, not taken: counter decrements, saturating at 0; target unchanged.
  - Miss, taken: allocate. valid = 1, tag and target written, counter = weakly-taken (1 followed by zeros). Any previous occupant is overwritten.
  - Miss, not taken: no table change.
- Simultaneous lookup and update to the same index in one cycle:
  - The lookup returns pre-update state; no bypass.
  - The new state is visible to a lookup on the following cycle.
- Statistics:
  - stat_branches increments on every upd_en.
  - stat_mispredicts increments on upd_en and upd_mispredict.
  - Both counters saturate at all ones and never wrap.
- CTR_W = 1 degenerates to last-outcome prediction; allocation sets the counter to 1.
- Storage: flip-flops only, no memory macro; no read latency.

Test Plan:
- Reset:
  - Assert RST mid-stream with lkup_pc = 0x0000_0104.
  - Required: pred_sel = 0, pred_target = 0, both stats = 0 immediately, without a clock edge.
- Allocate:
  - upd_en with upd_pc = 0x0000_0104 (index 1, tag 0x4), upd_taken = 1, upd_target = 0x0000_0200.
  - Next cycle, lookup 0x0000_0104 -> pred_sel = 1, pred_target = 0x0000_0200; stat_branches = 1.
- Hysteresis:
  - From the allocated state, one not-taken update -> pred_sel = 0 (counter 01).
  - One taken update -> pred_sel = 1 (counter 10).
  - Three more taken updates -> counter holds at 11.
  - Two not-taken updates -> pred_sel = 1 after the first, 0 after the second.
- Alias:
  - Allocate 0x0000_0104; then a taken update for 0x0000_0144 (same index 1, tag 0x5) with upd_target = 0x0000_0300.
  - Lookup 0x104 -> pred_sel = 0.
  - Lookup 0x144 -> pred_sel = 1, pred_target = 0x0000_0300.
- Same-cycle collision:
  - With counter 10 for 0x104: drive lookup 0x104 and a not-taken update for 0x104 in the same cycle.
  - That cycle: pred_sel = 1. Next cycle: pred_sel = 0.
- Stat saturation:
  - With STAT_W = 4, issue 20 updates, all with upd_mispredict = 1.
  - Required: stat_branches = 15 and stat_mispredicts = 15, holding at 15 with no wrap to 0.
